// File: rtl/mc_control_fsm_if.sv
// Control bundle between the multicycle sequencer and the datapath.
// The sequencer is the master: it consumes opcode/zero/mem_ready and drives every control strobe.
interface mc_control_fsm_if;
   logic [5:0] opcode;
   logic       zero;
   logic       mem_ready;

   logic       mem_req;
   logic       mem_we;
   logic       ir_we;
   logic       pc_we;
   logic       pc_sel;
   logic       reg_we;
   logic       reg_dst;
   logic       mem_to_reg;
   logic       alu_src_a;
   logic [1:0] alu_src_b;
   logic [1:0] alu_op;
   logic       illegal;
   logic       mem_timeout;
   logic [3:0] state;

   modport master (
      input  opcode, zero, mem_ready,
      output mem_req, mem_we, ir_we, pc_we, pc_sel, reg_we, reg_dst, mem_to_reg,
             alu_src_a, alu_src_b, alu_op, illegal, mem_timeout, state
   );

   modport slave (
      output opcode, zero, mem_ready,
      input  mem_req, mem_we, ir_we, pc_we, pc_sel, reg_we, reg_dst, mem_to_reg,
             alu_src_a, alu_src_b, alu_op, illegal, mem_timeout, state
   );
endinterface

// File: rtl/mc_control_fsm.sv
// Multicycle control sequencer: fetch, decode, execute, memory and write-back control.
// Optional build macro MC_CTRL_JUMP_EN adds the J instruction (JUMP state, pc_sel=1).
module mc_control_fsm #(
   parameter int unsigned WAIT_LIMIT = 15
) (
   input logic              clk,
   input logic              rst_n,
   mc_control_fsm_if.master ctrl_io
);

   typedef enum logic [3:0] {
      StFetch   = 4'd0,
      StDecode  = 4'd1,
      StExecR   = 4'd2,
      StExecI   = 4'd3,
      StMemAddr = 4'd4,
      StMemRd   = 4'd5,
      StMemWr   = 4'd6,
      StWbR     = 4'd7,
      StWbMem   = 4'd8,
      StBranch  = 4'd9,
      StJump    = 4'd10,
      StWbI     = 4'd11
   } state_e;

   localparam logic [5:0] OpRtype = 6'b000000;
   localparam logic [5:0] OpLw    = 6'b100011;
   localparam logic [5:0] OpSw    = 6'b101011;
   localparam logic [5:0] OpBeq   = 6'b000100;
   localparam logic [5:0] OpAddi  = 6'b001000;
   localparam logic [5:0] OpJ     = 6'b000010;

   state_e     state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic       timeout_q, timeout_d;

   logic       mem_req;
   logic       mem_we;
   logic       ir_we;
   logic       pc_we;
   logic       pc_sel;
   logic       reg_we;
   logic       reg_dst;
   logic       mem_to_reg;
   logic       alu_src_a;
   logic [1:0] alu_src_b;
   logic [1:0] alu_op;
   logic       illegal;
   logic       waiting;
   logic [4:0] cnt_inc;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= StFetch;
         cnt_q     <= 4'd0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         timeout_q <= timeout_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      ir_we      = 1'b0;
      pc_we      = 1'b0;
      pc_sel     = 1'b0;
      reg_we     = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'b00;
      alu_op     = 2'b00;
      illegal    = 1'b0;

      case (state_q)
         StFetch: begin
            mem_req   = 1'b1;
            alu_src_b = 2'b01;
            if (ctrl_io.mem_ready) begin
               ir_we   = 1'b1;
               pc_we   = 1'b1;
               state_d = StDecode;
            end
         end
         StDecode: begin
            // ALU precomputes PC + (imm << 2) so BRANCH can use it next cycle.
            alu_src_b = 2'b11;
            case (ctrl_io.opcode)
               OpRtype:     state_d = StExecR;
               OpAddi:      state_d = StExecI;
               OpLw, OpSw:  state_d = StMemAddr;
               OpBeq:       state_d = StBranch;
`ifdef MC_CTRL_JUMP_EN
               OpJ:         state_d = StJump;
`endif
               default: begin
                  illegal = 1'b1;
                  state_d = StFetch;
               end
            endcase
         end
         StExecR: begin
            alu_src_a = 1'b1;
            alu_op    = 2'b10;
            state_d   = StWbR;
         end
         StExecI: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            state_d   = StWbI;
         end
         StMemAddr: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            state_d   = (ctrl_io.opcode == OpSw) ? StMemWr : StMemRd;
         end
         StMemRd: begin
            mem_req = 1'b1;
            if (ctrl_io.mem_ready) state_d = StWbMem;
         end
         StMemWr: begin
            mem_req = 1'b1;
            mem_we  = 1'b1;
            if (ctrl_io.mem_ready) state_d = StFetch;
         end
         StWbR: begin
            reg_we  = 1'b1;
            reg_dst = 1'b1;
            state_d = StFetch;
         end
         StWbI: begin
            reg_we  = 1'b1;
            state_d = StFetch;
         end
         StWbMem: begin
            reg_we     = 1'b1;
            mem_to_reg = 1'b1;
            state_d    = StFetch;
         end
         StBranch: begin
            alu_src_a = 1'b1;
            alu_op    = 2'b01;
            pc_we     = ctrl_io.zero;
            state_d   = StFetch;
         end
`ifdef MC_CTRL_JUMP_EN
         StJump: begin
            pc_sel  = 1'b1;
            pc_we   = 1'b1;
            state_d = StFetch;
         end
`endif
         default: state_d = StFetch;
      endcase
   end

   // Wait counter saturates at 15; a request is never abandoned, only flagged.
   always_comb begin
      waiting   = mem_req & ~ctrl_io.mem_ready;
      cnt_inc   = {1'b0, cnt_q} + 5'd1;
      cnt_d     = 4'd0;
      timeout_d = timeout_q;
      if (waiting && (state_d == state_q)) begin
         cnt_d = (cnt_q == 4'hF) ? cnt_q : cnt_inc[3:0];
         if ({27'd0, cnt_inc} >= WAIT_LIMIT) timeout_d = 1'b1;
      end
   end

   // Reset blanks every output immediately, even before the state register clears.
   always_comb begin
      ctrl_io.mem_req     = rst_n & mem_req;
      ctrl_io.mem_we      = rst_n & mem_we;
      ctrl_io.ir_we       = rst_n & ir_we;
      ctrl_io.pc_we       = rst_n & pc_we;
      ctrl_io.pc_sel      = rst_n & pc_sel;
      ctrl_io.reg_we      = rst_n & reg_we;
      ctrl_io.reg_dst     = rst_n & reg_dst;
      ctrl_io.mem_to_reg  = rst_n & mem_to_reg;
      ctrl_io.alu_src_a   = rst_n & alu_src_a;
      ctrl_io.alu_src_b   = rst_n ? alu_src_b : 2'b00;
      ctrl_io.alu_op      = rst_n ? alu_op : 2'b00;
      ctrl_io.illegal     = rst_n & illegal;
      ctrl_io.mem_timeout = rst_n & timeout_q;
      ctrl_io.state       = rst_n ? state_q : 4'd0;
   end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Self-checking bench for mc_control_fsm: each instruction is expanded into its expected
// per-cycle control trace, then replayed against the DUT cycle by cycle.
module tb_mc_control_fsm;

   localparam int unsigned WaitLimit = 15;

   typedef struct packed {
      logic [3:0] st;
      logic       mem_req;
      logic       mem_we;
      logic       ir_we;
      logic       pc_we;
      logic       pc_sel;
      logic       reg_we;
      logic       reg_dst;
      logic       mem_to_reg;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic       illegal;
      logic       mem_timeout;
   } outs_t;

   typedef struct {
      logic       rdy;
      logic       zro;
      logic [5:0] op;
      outs_t      exp;
      string      tag;
   } step_t;

   typedef enum int {KindR, KindAddi, KindLw, KindSw, KindBeq, KindJ, KindIll} kind_e;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   compared = 0;
   int   mismatched = 0;
   int   wait_run = 0;
   logic to_flag = 1'b0;
   step_t q[$];

   mc_control_fsm_if ifc ();

   mc_control_fsm #(.WAIT_LIMIT(WaitLimit)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .ctrl_io(ifc.master)
   );

   always #5 clk = ~clk;

   function automatic kind_e classify(input logic [5:0] op);
      case (op)
         6'b000000: return KindR;
         6'b001000: return KindAddi;
         6'b100011: return KindLw;
         6'b101011: return KindSw;
         6'b000100: return KindBeq;
`ifdef MC_CTRL_JUMP_EN
         6'b000010: return KindJ;
`endif
         default:   return KindIll;
      endcase
   endfunction

   function automatic outs_t o(input logic [3:0] st);
      outs_t e;
      e = '0;
      e.st = st;
      return e;
   endfunction

   function automatic logic rbit();
      return 1'($urandom_range(0, 1));
   endfunction

   function automatic void push(input outs_t e, input logic rdy, input logic z,
                                input logic [5:0] op, input string tag);
      step_t s;
      s.rdy = rdy;
      s.zro = z;
      s.op  = op;
      s.exp = e;
      s.tag = tag;
      q.push_back(s);
   endfunction

   // Expected control trace of one instruction, from the per-state rules.
   function automatic void add_instr(input logic [5:0] op, input int fw, input int mw,
                                     input logic z, input string tag);
      outs_t e;
      kind_e k;
      k = classify(op);
      for (int i = 0; i < fw; i++) begin
         e = o(4'd0); e.mem_req = 1'b1; e.alu_src_b = 2'b01;
         push(e, 1'b0, rbit(), op, {tag, "/fetch_wait"});
      end
      e = o(4'd0); e.mem_req = 1'b1; e.alu_src_b = 2'b01; e.ir_we = 1'b1; e.pc_we = 1'b1;
      push(e, 1'b1, rbit(), op, {tag, "/fetch"});
      e = o(4'd1); e.alu_src_b = 2'b11;
      if (k == KindIll) begin
         e.illegal = 1'b1;
         push(e, rbit(), rbit(), op, {tag, "/decode_illegal"});
         return;
      end
      push(e, rbit(), rbit(), op, {tag, "/decode"});
      case (k)
         KindR: begin
            e = o(4'd2); e.alu_src_a = 1'b1; e.alu_op = 2'b10;
            push(e, rbit(), rbit(), op, {tag, "/exec_r"});
            e = o(4'd7); e.reg_we = 1'b1; e.reg_dst = 1'b1;
            push(e, rbit(), rbit(), op, {tag, "/wb_r"});
         end
         KindAddi: begin
            e = o(4'd3); e.alu_src_a = 1'b1; e.alu_src_b = 2'b10;
            push(e, rbit(), rbit(), op, {tag, "/exec_i"});
            e = o(4'd11); e.reg_we = 1'b1;
            push(e, rbit(), rbit(), op, {tag, "/wb_i"});
         end
         KindLw, KindSw: begin
            e = o(4'd4); e.alu_src_a = 1'b1; e.alu_src_b = 2'b10;
            push(e, rbit(), rbit(), op, {tag, "/mem_addr"});
            e = (k == KindLw) ? o(4'd5) : o(4'd6);
            e.mem_req = 1'b1;
            e.mem_we  = (k == KindSw);
            for (int i = 0; i < mw; i++) push(e, 1'b0, rbit(), op, {tag, "/mem_wait"});
            push(e, 1'b1, rbit(), op, {tag, "/mem_done"});
            if (k == KindLw) begin
               e = o(4'd8); e.reg_we = 1'b1; e.mem_to_reg = 1'b1;
               push(e, rbit(), rbit(), op, {tag, "/wb_mem"});
            end
         end
         KindBeq: begin
            e = o(4'd9); e.alu_src_a = 1'b1; e.alu_op = 2'b01; e.pc_we = z;
            push(e, rbit(), z, op, {tag, "/branch"});
         end
         KindJ: begin
            e = o(4'd10); e.pc_sel = 1'b1; e.pc_we = 1'b1;
            push(e, rbit(), rbit(), op, {tag, "/jump"});
         end
         default: ;
      endcase
   endfunction

   function automatic outs_t observed();
      return {ifc.state, ifc.mem_req, ifc.mem_we, ifc.ir_we, ifc.pc_we, ifc.pc_sel,
              ifc.reg_we, ifc.reg_dst, ifc.mem_to_reg, ifc.alu_src_a, ifc.alu_src_b,
              ifc.alu_op, ifc.illegal, ifc.mem_timeout};
   endfunction

   task automatic check(input outs_t exp, input string tag);
      outs_t got;
      got = observed();
      compared++;
      assert (got === exp)
      else begin
         mismatched++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   // Replays n queued cycles (all when n < 0), tracking the wait-timeout model.
   task automatic run_steps(input int n);
      step_t s;
      outs_t e;
      int    done;
      done = 0;
      while (q.size() > 0 && (n < 0 || done < n)) begin
         s = q.pop_front();
         @(negedge clk);
         rst_n         = 1'b1;
         ifc.mem_ready = s.rdy;
         ifc.zero      = s.zro;
         ifc.opcode    = s.op;
         #1;
         e = s.exp;
         e.mem_timeout = to_flag;
         check(e, s.tag);
         if (e.mem_req && !s.rdy) begin
            if (wait_run < 15) wait_run++;
            if (wait_run >= int'(WaitLimit)) to_flag = 1'b1;
         end else begin
            wait_run = 0;
         end
         done++;
      end
   endtask

   task automatic reset_cycles(input int n, input string tag);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         rst_n         = 1'b0;
         ifc.mem_ready = rbit();
         ifc.zero      = rbit();
         #1;
         check('0, tag);
      end
      wait_run = 0;
      to_flag  = 1'b0;
   endtask

   initial begin
      logic [5:0] legal [6];
      logic [5:0] op;
      legal[0] = 6'b000000; legal[1] = 6'b001000; legal[2] = 6'b100011;
      legal[3] = 6'b101011; legal[4] = 6'b000100; legal[5] = 6'b000010;
      ifc.opcode    = 6'd0;
      ifc.zero      = 1'b0;
      ifc.mem_ready = 1'b0;

      reset_cycles(2, "por");

      add_instr(6'b000000, 0, 0, 1'b0, "r_type");
      add_instr(6'b100011, 0, 2, 1'b0, "lw_wait2");
      add_instr(6'b000100, 0, 0, 1'b1, "beq_taken");
      add_instr(6'b000100, 0, 0, 1'b0, "beq_not_taken");
      add_instr(6'b000010, 0, 0, 1'b0, "jump");
      add_instr(6'b101011, 1, 1, 1'b0, "sw_wait");
      add_instr(6'b001000, 0, 0, 1'b0, "addi");
      add_instr(6'b111111, 0, 0, 1'b0, "illegal_op");
      run_steps(-1);

      // Reset in the middle of an LW that is waiting in MEM_RD.
      add_instr(6'b100011, 0, 3, 1'b0, "lw_cut");
      run_steps(4);
      q.delete();
      reset_cycles(3, "reset_mid_lw");
      add_instr(6'b000000, 0, 0, 1'b0, "after_reset");
      run_steps(-1);

      for (int i = 0; i < 60; i++) begin
         if ($urandom_range(0, 3) == 0) op = 6'($urandom_range(0, 63));
         else op = legal[$urandom_range(0, 5)];
         add_instr(op, $urandom_range(0, 3), $urandom_range(0, 3), rbit(),
                   $sformatf("rnd%0d_op%02h", i, op));
         run_steps(-1);
      end

      add_instr(6'b000000, 20, 0, 1'b0, "fetch_timeout");
      add_instr(6'b100011, 0, 1, 1'b0, "sticky_lw");
      add_instr(6'b000100, 0, 0, 1'b1, "sticky_beq");
      run_steps(-1);
      reset_cycles(1, "timeout_reset");
      add_instr(6'b001000, 0, 0, 1'b0, "timeout_cleared");
      run_steps(-1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
